// File: rtl/axis_vid_pkg.sv
// Shared types and constants for the AXI4-Stream video pattern generator.
package axis_vid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BURST,
    ST_GAP,
    ST_LINE_GAP,
    ST_FRAME_GAP,
    ST_DONE
  } state_t;

  localparam logic [1:0] MODE_COUNTER = 2'd0;
  localparam logic [1:0] MODE_BARS    = 2'd1;
  localparam logic [1:0] MODE_RAMP    = 2'd2;
  localparam logic [1:0] MODE_FILL    = 2'd3;

  // Index 0 is the leftmost bar (white), index 7 the rightmost (black).
  localparam logic [7:0][23:0] BAR_COLORS = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

endpackage

// File: rtl/axis_video_pattern_gen_if.sv
// AXI4-Stream video bus: 24-bit {R,G,B} pixel, tuser = start of frame, tlast = end of line.
interface axis_video_pattern_gen_if;
  logic [23:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;

  modport master (output tdata, tvalid, tuser, tlast, input tready);
  modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/axis_vid_pattern_lut.sv
// Pixel formatter: turns (mode, x, pixel counter, fill colour) into a registered tdata word.
module axis_vid_pattern_lut
  import axis_vid_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int COMP_W   = 6,
  parameter int XW       = 10,
  parameter int PW       = 18
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load,
  input  logic [1:0]    mode,
  input  logic [XW-1:0] x,
  input  logic [PW-1:0] p,
  input  logic [23:0]   fill_color,
  output logic [23:0]   tdata
);

  logic [23:0] pix;
  logic [7:0]  r, g, b, ramp;
  logic [2:0]  bar;

  always_comb begin
    // Counter components are left-justified so narrow COMP_W still spans the full range.
    r    = 8'(p[3*COMP_W-1:2*COMP_W]) << (8 - COMP_W);
    g    = 8'(p[2*COMP_W-1:COMP_W])   << (8 - COMP_W);
    b    = 8'(p[COMP_W-1:0])          << (8 - COMP_W);
    bar  = 3'((32'(x) * 32'd8) / 32'(H_ACTIVE));
    ramp = 8'(x);
    case (mode)
      MODE_COUNTER: pix = {r, g, b};
      MODE_BARS:    pix = BAR_COLORS[bar];
      MODE_RAMP:    pix = {ramp, ramp, ramp};
      default:      pix = fill_color;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     tdata <= '0;
    else if (load) tdata <= pix;
  end

endmodule

// File: rtl/axis_video_pattern_gen.sv
// Paced AXI4-Stream test-pattern source with burst/gap, line and frame blanking; honours tready.
module axis_video_pattern_gen
  import axis_vid_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int COMP_W    = 6,
  parameter int BURST_LEN = 4,
  parameter int GAP_LEN   = 3,
  parameter int LINE_GAP  = 1750,
  parameter int FRAME_GAP = 500000
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [23:0]          fill_color,
  input  logic [15:0]          num_frames,
  axis_video_pattern_gen_if.master m_axis_video,
  output logic                 busy,
  output logic                 frame_done,
  output logic [15:0]          frame_count
);

  localparam int XW   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int PW   = 3 * COMP_W;
  localparam int BW   = $clog2(BURST_LEN + 1);
  localparam int GM0  = (GAP_LEN > LINE_GAP) ? GAP_LEN : LINE_GAP;
  localparam int GMAX = (GM0 > FRAME_GAP) ? GM0 : FRAME_GAP;
  localparam int GW   = (GMAX > 0) ? $clog2(GMAX + 1) : 1;

  state_t        state, after_frame;
  logic [1:0]    mode_q, mode_use;
  logic [15:0]   nframes_q, fc_seen;
  logic [BW-1:0] bcnt;
  logic [GW-1:0] gcnt;
  // nx/ny/p describe the next beat to be loaded, not the one on the bus.
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic [PW-1:0] p;
  logic          tvalid_q, tuser_q, tlast_q;
  logic          xfer, eol, eof, burst_end, gap_done, go_on;
  logic          frame_end, start_frame, load;

  assign m_axis_video.tvalid = tvalid_q;
  assign m_axis_video.tuser  = tuser_q;
  assign m_axis_video.tlast  = tlast_q;

  always_comb begin
    xfer      = tvalid_q && m_axis_video.tready;
    eol       = tlast_q;
    // After the last beat of a frame is loaded, the row counter has wrapped to 0.
    eof       = tlast_q && (ny == '0);
    burst_end = (bcnt == BW'(BURST_LEN - 1));
    gap_done  = (gcnt == '0);
    fc_seen   = (state == ST_BURST) ? frame_count + 16'd1 : frame_count;
    go_on     = enable && !((nframes_q != 16'd0) && (fc_seen == nframes_q));
    frame_end = ((state == ST_BURST) && xfer && eof && (FRAME_GAP == 0)) ||
                ((state == ST_FRAME_GAP) && gap_done);
    start_frame = ((state == ST_IDLE) && enable) || (frame_end && go_on);
    load = start_frame ||
           (((state == ST_GAP) || (state == ST_LINE_GAP)) && gap_done) ||
           ((state == ST_BURST) && xfer && !eof &&
            (eol ? (LINE_GAP == 0) : !(burst_end && (GAP_LEN > 0))));
    mode_use = start_frame ? mode : mode_q;
    if (start_frame)
      after_frame = ST_BURST;
    else if ((nframes_q != 16'd0) && (fc_seen == nframes_q))
      after_frame = ST_DONE;
    else
      after_frame = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      mode_q      <= MODE_COUNTER;
      nframes_q   <= '0;
      bcnt        <= '0;
      gcnt        <= '0;
    end else begin
      frame_done <= 1'b0;
      if (start_frame) mode_q <= mode;
      case (state)
        ST_IDLE: if (enable) begin
          state       <= ST_BURST;
          busy        <= 1'b1;
          nframes_q   <= num_frames;
          frame_count <= '0;
          bcnt        <= '0;
        end
        ST_BURST: if (xfer) begin
          if (eof) begin
            frame_done  <= 1'b1;
            frame_count <= frame_count + 16'd1;
            bcnt        <= '0;
            if (FRAME_GAP > 0) begin
              state <= ST_FRAME_GAP;
              gcnt  <= GW'(FRAME_GAP - 1);
            end else begin
              state <= after_frame;
              busy  <= (after_frame == ST_BURST);
            end
          end else if (eol) begin
            bcnt <= '0;
            if (LINE_GAP > 0) begin
              state <= ST_LINE_GAP;
              gcnt  <= GW'(LINE_GAP - 1);
            end
          end else if (burst_end) begin
            bcnt <= '0;
            if (GAP_LEN > 0) begin
              state <= ST_GAP;
              gcnt  <= GW'(GAP_LEN - 1);
            end
          end else begin
            bcnt <= bcnt + BW'(1);
          end
        end
        ST_GAP, ST_LINE_GAP: begin
          if (gap_done) state <= ST_BURST;
          else          gcnt  <= gcnt - GW'(1);
        end
        ST_FRAME_GAP: begin
          if (gap_done) begin
            state <= after_frame;
            busy  <= (after_frame == ST_BURST);
          end else begin
            gcnt <= gcnt - GW'(1);
          end
        end
        ST_DONE: if (!enable) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tvalid_q <= 1'b0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
      nx       <= '0;
      ny       <= '0;
      p        <= '0;
    end else if (load) begin
      tvalid_q <= 1'b1;
      tuser_q  <= (nx == '0) && (ny == '0);
      tlast_q  <= (nx == XW'(H_ACTIVE - 1));
      p        <= p + PW'(1);
      if (nx == XW'(H_ACTIVE - 1)) begin
        nx <= '0;
        ny <= (ny == YW'(V_ACTIVE - 1)) ? '0 : ny + YW'(1);
      end else begin
        nx <= nx + XW'(1);
      end
    end else if (xfer) begin
      tvalid_q <= 1'b0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
    end
  end

  axis_vid_pattern_lut #(
    .H_ACTIVE (H_ACTIVE),
    .COMP_W   (COMP_W),
    .XW       (XW),
    .PW       (PW)
  ) u_lut (
    .clk        (clk),
    .rstn       (rstn),
    .load       (load),
    .mode       (mode_use),
    .x          (nx),
    .p          (p),
    .fill_color (fill_color),
    .tdata      (m_axis_video.tdata)
  );

endmodule
